packet_reassembly_buffer: RTL and testbench

- Multi-entry flit-to-packet reassembly stage in the packet controller, between the NoC flit input and the packet consumer.
- Collects HEAD/BODY/TAIL flits per packet_id into one of NUM_ENTRIES entries and expires stale partial packets.
- Replays completed packets in completion order as a flit stream with a last marker.
- Reports sequence, overflow, duplicate and orphan errors explicitly.

---
 rtl/packet_reassembly_buffer.sv | 254 +++++++++++++++++++++++++
 tb/tb_packet_reassembly_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_reassembly_buffer.sv
// Flit-to-packet reassembly: collects HEAD/BODY/TAIL per packet_id, expires stale partials, replays in completion order. Optional counters: PACKET_REASSEMBLY_STATS_EN.
// Replay starts the cycle after TAIL; in_flit_ready drops only for an unplaceable HEAD; out_flit holds until out_flit_ready.
package types;
    typedef enum logic [1:0] {FT_IDLE = 2'd0, FT_HEAD = 2'd1, FT_BODY = 2'd2, FT_TAIL = 2'd3} flit_type_t;
    typedef struct packed {
        flit_type_t  ftype;
        logic [7:0]  packet_id;
        logic [7:0]  flit_num;
        logic [31:0] payload;
    } flit_t;
endpackage

module packet_reassembly_buffer #(
    parameter int NUM_ENTRIES = 8,
    parameter int MAX_FLITS   = 16,
    parameter int EXPIRE_TIME = 255,
    parameter int TIMER_WIDTH = $clog2(EXPIRE_TIME + 1)
) (
    input  logic                             nocclk,
    input  logic                             rst_n,
    input  types::flit_t                     in_flit,
    input  logic                             in_flit_valid,
    output logic                             in_flit_ready,
    output types::flit_t                     out_flit,
    output logic                             out_flit_valid,
    input  logic                             out_flit_ready,
    output logic                             out_flit_last,
    output logic                             drop_valid,
    output logic [1:0]                       drop_reason,
    output logic [NUM_ENTRIES-1:0]           expired,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy
`ifdef PACKET_REASSEMBLY_STATS_EN
    ,
    output logic [15:0]                      stat_completed,
    output logic [15:0]                      stat_dropped
`endif
);
    import types::*;

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam int PTR_W = $clog2(MAX_FLITS);
    localparam logic [1:0] R_ORPHAN = 2'd0, R_SEQ = 2'd1, R_OVF = 2'd2, R_DUP = 2'd3;

    typedef enum logic [1:0] {E_FREE, E_FILL, E_DONE, E_DRAIN} entry_state_t;

    entry_state_t           st_q  [NUM_ENTRIES];
    entry_state_t           st_d  [NUM_ENTRIES];
    logic [7:0]             pid_q [NUM_ENTRIES];
    logic [7:0]             pid_d [NUM_ENTRIES];
    logic [7:0]             exp_q [NUM_ENTRIES];
    logic [7:0]             exp_d [NUM_ENTRIES];
    logic [CNT_W-1:0]       cnt_q [NUM_ENTRIES];
    logic [CNT_W-1:0]       cnt_d [NUM_ENTRIES];
    logic [TIMER_WIDTH-1:0] tmr_q [NUM_ENTRIES];
    logic [TIMER_WIDTH-1:0] tmr_d [NUM_ENTRIES];
    flit_t                  mem_q [NUM_ENTRIES][MAX_FLITS];
    logic [IDX_W-1:0]       fifo_q [NUM_ENTRIES];

    logic [IDX_W-1:0]       wp_q, wp_d, hp_q, hp_d;
    logic [IDX_W:0]         fcnt_q, fcnt_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic                   drop_valid_q, drop_valid_d;
    logic [1:0]             drop_reason_q, drop_reason_d;
    logic [NUM_ENTRIES-1:0] expired_q, expired_d;
    logic [OCC_W-1:0]       occupancy_q, occupancy_d;

    logic                   hit, free_any, is_head, is_bt, acc, touch;
    logic                   out_vld, out_last, out_hs, last_hs, push, mem_we;
    logic [IDX_W-1:0]       hit_idx, free_idx, head_idx, mem_idx;
    logic [PTR_W-1:0]       mem_slot;

    // Descending scan so the lowest-index FREE entry wins allocation.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (st_q[i] == E_FILL && pid_q[i] == in_flit.packet_id) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (st_q[i] == E_FREE) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign is_head       = (in_flit.ftype == FT_HEAD);
    assign is_bt         = (in_flit.ftype == FT_BODY) || (in_flit.ftype == FT_TAIL);
    assign in_flit_ready = !(is_head && !hit && !free_any);
    assign acc           = in_flit_valid && in_flit_ready;
    assign touch         = acc && hit && (is_head || is_bt);

    assign out_vld  = (fcnt_q != '0);
    assign head_idx = fifo_q[hp_q];
    assign out_last = out_vld && (CNT_W'(rd_ptr_q) == cnt_q[head_idx] - CNT_W'(1));
    assign out_hs   = out_vld && out_flit_ready;
    assign last_hs  = out_hs && out_last;

    always_comb begin
        st_d          = st_q;
        pid_d         = pid_q;
        exp_d         = exp_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        rd_ptr_d      = rd_ptr_q;
        drop_valid_d  = 1'b0;
        drop_reason_d = '0;
        expired_d     = '0;
        push          = 1'b0;
        mem_we        = 1'b0;
        mem_idx       = hit_idx;
        mem_slot      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (st_q[i] == E_FILL && !(touch && hit_idx == IDX_W'(i))) begin
                if (tmr_q[i] == TIMER_WIDTH'(EXPIRE_TIME)) begin
                    st_d[i]      = E_FREE;
                    expired_d[i] = 1'b1;
                end else begin
                    tmr_d[i] = tmr_q[i] + TIMER_WIDTH'(1);
                end
            end
        end
        if (acc && is_head) begin
            // A duplicate HEAD restarts the matching entry instead of taking a new one.
            mem_idx = hit ? hit_idx : free_idx;
            if (hit) begin
                drop_valid_d  = 1'b1;
                drop_reason_d = R_DUP;
            end
            st_d[mem_idx]  = E_FILL;
            pid_d[mem_idx] = in_flit.packet_id;
            exp_d[mem_idx] = 8'd1;
            cnt_d[mem_idx] = CNT_W'(1);
            tmr_d[mem_idx] = '0;
            mem_we         = 1'b1;
        end else if (acc && is_bt) begin
            if (!hit) begin
                drop_valid_d  = 1'b1;
                drop_reason_d = R_ORPHAN;
            end else if (in_flit.flit_num != exp_q[hit_idx]) begin
                st_d[hit_idx] = E_FREE;
                drop_valid_d  = 1'b1;
                drop_reason_d = R_SEQ;
            end else if (cnt_q[hit_idx] == CNT_W'(MAX_FLITS)) begin
                st_d[hit_idx] = E_FREE;
                drop_valid_d  = 1'b1;
                drop_reason_d = R_OVF;
            end else begin
                mem_we         = 1'b1;
                mem_slot       = PTR_W'(cnt_q[hit_idx]);
                cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
                exp_d[hit_idx] = exp_q[hit_idx] + 8'd1;
                tmr_d[hit_idx] = '0;
                if (in_flit.ftype == FT_TAIL) begin
                    st_d[hit_idx] = E_DONE;
                    push          = 1'b1;
                end
            end
        end
        if (out_vld && st_q[head_idx] == E_DONE) st_d[head_idx] = E_DRAIN;
        if (out_hs) begin
            if (out_last) begin
                rd_ptr_d       = '0;
                st_d[head_idx] = E_FREE;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
        wp_d        = wp_q + IDX_W'(push);
        hp_d        = hp_q + IDX_W'(last_hs);
        fcnt_d      = fcnt_q + (IDX_W+1)'(push) - (IDX_W+1)'(last_hs);
        occupancy_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (st_d[i] != E_FREE) occupancy_d = occupancy_d + OCC_W'(1);
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                st_q[i]  <= E_FREE;
                pid_q[i] <= '0;
                exp_q[i] <= '0;
                cnt_q[i] <= '0;
                tmr_q[i] <= '0;
            end
            wp_q          <= '0;
            hp_q          <= '0;
            fcnt_q        <= '0;
            rd_ptr_q      <= '0;
            drop_valid_q  <= 1'b0;
            drop_reason_q <= '0;
            expired_q     <= '0;
            occupancy_q   <= '0;
        end else begin
            st_q          <= st_d;
            pid_q         <= pid_d;
            exp_q         <= exp_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            wp_q          <= wp_d;
            hp_q          <= hp_d;
            fcnt_q        <= fcnt_d;
            rd_ptr_q      <= rd_ptr_d;
            drop_valid_q  <= drop_valid_d;
            drop_reason_q <= drop_reason_d;
            expired_q     <= expired_d;
            occupancy_q   <= occupancy_d;
        end
    end

    // Payload storage and completion queue carry no reset; reads are gated by out_vld.
    always_ff @(posedge nocclk) begin
        if (mem_we) mem_q[mem_idx][mem_slot] <= in_flit;
        if (push)   fifo_q[wp_q] <= hit_idx;
    end

    assign out_flit       = out_vld ? mem_q[head_idx][rd_ptr_q] : '0;
    assign out_flit_valid = out_vld;
    assign out_flit_last  = out_last;
    assign drop_valid     = drop_valid_q;
    assign drop_reason    = drop_reason_q;
    assign expired        = expired_q;
    assign occupancy      = occupancy_q;

`ifdef PACKET_REASSEMBLY_STATS_EN
    logic [15:0] stat_completed_q, stat_completed_d, stat_dropped_q, stat_dropped_d;
    logic [31:0] drop_sum;

    always_comb begin
        drop_sum         = 32'(stat_dropped_q) + 32'(drop_valid_q) + 32'($countones(expired_q));
        stat_dropped_d   = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
        stat_completed_d = (last_hs && stat_completed_q != 16'hFFFF) ? stat_completed_q + 16'd1 : stat_completed_q;
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            stat_completed_q <= '0;
            stat_dropped_q   <= '0;
        end else begin
            stat_completed_q <= stat_completed_d;
            stat_dropped_q   <= stat_dropped_d;
        end
    end

    assign stat_completed = stat_completed_q;
    assign stat_dropped   = stat_dropped_q;
`endif
endmodule

// File: tb/tb_packet_reassembly_buffer.sv
// Bench for packet_reassembly_buffer: directed scenarios plus randomized traffic against a packet-level model.
`timescale 1ns/1ps
module tb_packet_reassembly_buffer;
    import types::*;

    localparam int NE   = 8;
    localparam int MAXF = 4;
    localparam int EXP  = 255;

    logic         nocclk = 1'b0;
    logic         rst_n;
    flit_t        in_flit;
    logic         in_flit_valid, in_flit_ready;
    flit_t        out_flit;
    logic         out_flit_valid, out_flit_ready, out_flit_last;
    logic         drop_valid;
    logic [1:0]   drop_reason;
    logic [NE-1:0] expired;
    logic [3:0]   occupancy;
`ifdef PACKET_REASSEMBLY_STATS_EN
    logic [15:0]  stat_completed, stat_dropped;
`endif

    packet_reassembly_buffer #(.NUM_ENTRIES(NE), .MAX_FLITS(MAXF), .EXPIRE_TIME(EXP)) dut (
        .nocclk(nocclk), .rst_n(rst_n),
        .in_flit(in_flit), .in_flit_valid(in_flit_valid), .in_flit_ready(in_flit_ready),
        .out_flit(out_flit), .out_flit_valid(out_flit_valid), .out_flit_ready(out_flit_ready),
        .out_flit_last(out_flit_last), .drop_valid(drop_valid), .drop_reason(drop_reason),
        .expired(expired), .occupancy(occupancy)
`ifdef PACKET_REASSEMBLY_STATS_EN
        , .stat_completed(stat_completed), .stat_dropped(stat_dropped)
`endif
    );

    always #5 nocclk = ~nocclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Packet-level model: partial packets per id, flattened replay stream, busy entry count.
    bit    m_fill [16];
    int    m_exp  [16];
    int    m_tmr  [16];
    int    m_cnt  [16];
    flit_t m_pkt  [16][MAXF];
    flit_t q_flit [$];
    bit    q_last [$];
    int    m_busy, m_reason, m_expcnt;
    bit    m_drop;

    bit    exp_rdy, exp_ov, exp_ol;
    flit_t exp_of;
    logic  obs_rdy, obs_ov, obs_ol, obs_drop;
    flit_t obs_of;
    logic [1:0]    obs_reason;
    logic [NE-1:0] obs_exp;
    logic [3:0]    obs_occ;

    function automatic flit_t mk(input flit_type_t t, input int pid, input int num);
        flit_t f;
        f.ftype     = t;
        f.packet_id = 8'(pid);
        f.flit_num  = 8'(num);
        f.payload   = $urandom;
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_fill[i] = 0; m_exp[i] = 0; m_tmr[i] = 0; m_cnt[i] = 0;
        end
        q_flit.delete();
        q_last.delete();
        m_busy = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_flit_valid = 1'b0; in_flit = '0; out_flit_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge nocclk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive, sample pre-edge outputs, advance model, sample post-edge outputs.
    task automatic cycle(input bit v, input flit_t f, input bit ordy);
        int p;
        int tp;
        in_flit_valid = v; in_flit = f; out_flit_ready = ordy;
        #1;
        obs_rdy = in_flit_ready; obs_ov = out_flit_valid; obs_of = out_flit; obs_ol = out_flit_last;
        p       = int'(f.packet_id[3:0]);
        exp_rdy = !(f.ftype == FT_HEAD && !m_fill[p] && m_busy >= NE);
        exp_ov  = (q_flit.size() > 0);
        exp_of  = exp_ov ? q_flit[0] : '0;
        exp_ol  = exp_ov ? q_last[0] : 1'b0;
        m_drop = 0; m_reason = 0; m_expcnt = 0; tp = -1;
        if (exp_ov && ordy) begin
            if (q_last[0]) m_busy--;
            void'(q_flit.pop_front());
            void'(q_last.pop_front());
        end
        if (v && exp_rdy) begin
            if (f.ftype == FT_HEAD) begin
                tp = p;
                if (m_fill[p]) begin m_drop = 1; m_reason = 3; end
                else m_busy++;
                m_fill[p] = 1; m_cnt[p] = 1; m_pkt[p][0] = f; m_exp[p] = 1; m_tmr[p] = 0;
            end else if (f.ftype == FT_BODY || f.ftype == FT_TAIL) begin
                if (!m_fill[p]) begin
                    m_drop = 1; m_reason = 0;
                end else begin
                    tp = p;
                    if (int'(f.flit_num) != m_exp[p]) begin
                        m_drop = 1; m_reason = 1; m_fill[p] = 0; m_busy--;
                    end else if (m_cnt[p] == MAXF) begin
                        m_drop = 1; m_reason = 2; m_fill[p] = 0; m_busy--;
                    end else begin
                        m_pkt[p][m_cnt[p]] = f;
                        m_cnt[p]++; m_exp[p]++; m_tmr[p] = 0;
                        if (f.ftype == FT_TAIL) begin
                            for (int k = 0; k < m_cnt[p]; k++) begin
                                q_flit.push_back(m_pkt[p][k]);
                                q_last.push_back(k == m_cnt[p] - 1);
                            end
                            m_fill[p] = 0;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (m_fill[i] && i != tp) begin
                if (m_tmr[i] == EXP) begin m_fill[i] = 0; m_busy--; m_expcnt++; end
                else m_tmr[i]++;
            end
        end
        @(posedge nocclk);
        #1;
        obs_drop = drop_valid; obs_reason = drop_reason; obs_exp = expired; obs_occ = occupancy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_flit_valid = 1'b0; in_flit = '0; out_flit_ready = 1'b1;
        model_clear();
        #2;
        n_tests++; if (in_flit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_flit_ready); end
        n_tests++; if (out_flit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_flit_valid); end
        n_tests++; if (out_flit_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_flit_last); end
        n_tests++; if (out_flit !== '0) begin n_fail++; $display("FAIL reset_out_flit: got %h expected 0", out_flit); end
        n_tests++; if (drop_valid !== 1'b0 || drop_reason !== 2'd0) begin n_fail++; $display("FAIL reset_drop: got %b/%0d expected 0/0", drop_valid, drop_reason); end
        n_tests++; if (expired !== '0) begin n_fail++; $display("FAIL reset_expired: got %h expected 0", expired); end
        n_tests++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        do_reset();
    endtask

    task automatic test_basic();
        flit_t s [4];
        do_reset();
        s[0] = mk(FT_HEAD, 5, 0); s[1] = mk(FT_BODY, 5, 1); s[2] = mk(FT_BODY, 5, 2); s[3] = mk(FT_TAIL, 5, 3);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, s[i], 1'b1);
            n_tests++; if (obs_ov !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_out flit %0d: got %b expected 0", i, obs_ov); end
            if (i == 0) begin
                n_tests++; if (obs_occ !== 4'd1) begin n_fail++; $display("FAIL basic_occ_head: got %0d expected 1", obs_occ); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1);
            n_tests++; if (obs_ov !== 1'b1 || obs_of !== s[i]) begin n_fail++; $display("FAIL basic_replay %0d: got v=%b %h expected v=1 %h", i, obs_ov, obs_of, s[i]); end
            n_tests++; if (obs_ol !== (i == 3)) begin n_fail++; $display("FAIL basic_last %0d: got %b expected %b", i, obs_ol, (i == 3)); end
        end
        n_tests++; if (obs_occ !== 4'd0) begin n_fail++; $display("FAIL basic_occ_end: got %0d expected 0", obs_occ); end
    endtask

    task automatic test_interleave();
        flit_t s [6];
        flit_t want [6];
        flit_t got [$];
        int drops = 0;
        do_reset();
        s[0] = mk(FT_HEAD, 1, 0); s[1] = mk(FT_HEAD, 2, 0); s[2] = mk(FT_BODY, 1, 1);
        s[3] = mk(FT_BODY, 2, 1); s[4] = mk(FT_TAIL, 2, 2); s[5] = mk(FT_TAIL, 1, 2);
        want = '{s[1], s[3], s[4], s[0], s[2], s[5]};
        for (int i = 0; i < 18; i++) begin
            cycle(i < 6, (i < 6) ? s[i] : flit_t'('0), 1'b1);
            if (obs_ov) got.push_back(obs_of);
            if (obs_drop) drops++;
        end
        n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL interleave_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_tests++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL interleave_order %0d: got %h expected %h", i, got[i], want[i]); end
        end
        n_tests++; if (drops != 0) begin n_fail++; $display("FAIL interleave_drops: got %0d expected 0", drops); end
    endtask

    task automatic test_full();
        flit_t h8;
        int last_c = -1;
        int rdy_c  = -1;
        do_reset();
        for (int i = 0; i < NE; i++) cycle(1'b1, mk(FT_HEAD, i, 0), 1'b0);
        h8 = mk(FT_HEAD, 8, 0);
        cycle(1'b1, h8, 1'b0);
        n_tests++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", obs_rdy); end
        cycle(1'b1, mk(FT_TAIL, 0, 1), 1'b0);
        for (int c = 0; c < 10 && rdy_c < 0; c++) begin
            cycle(1'b1, h8, 1'b1);
            if (obs_ov && obs_ol && last_c < 0) last_c = c;
            if (obs_rdy) rdy_c = c;
        end
        n_tests++; if (last_c < 0 || rdy_c != last_c + 1) begin n_fail++; $display("FAIL full_realloc: ready at %0d expected %0d", rdy_c, last_c + 1); end
        n_tests++; if (obs_occ !== 4'd8) begin n_fail++; $display("FAIL full_occ: got %0d expected 8", obs_occ); end
    endtask

    task automatic test_seq_orphan();
        do_reset();
        cycle(1'b1, mk(FT_HEAD, 3, 0), 1'b1);
        cycle(1'b1, mk(FT_BODY, 3, 2), 1'b1);
        n_tests++; if (obs_drop !== 1'b1 || obs_reason !== 2'd1) begin n_fail++; $display("FAIL seq_drop: got %b/%0d expected 1/1", obs_drop, obs_reason); end
        n_tests++; if (obs_occ !== 4'd0) begin n_fail++; $display("FAIL seq_occ: got %0d expected 0", obs_occ); end
        cycle(1'b1, mk(FT_BODY, 3, 1), 1'b1);
        n_tests++; if (obs_drop !== 1'b1 || obs_reason !== 2'd0) begin n_fail++; $display("FAIL orphan_drop: got %b/%0d expected 1/0", obs_drop, obs_reason); end
    endtask

    task automatic test_expire();
        int early = 0;
        do_reset();
        cycle(1'b1, mk(FT_HEAD, 7, 0), 1'b1);
        for (int i = 0; i < EXP; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (obs_exp !== '0) early++;
        end
        n_tests++; if (early != 0 || obs_occ !== 4'd1) begin n_fail++; $display("FAIL expire_early: got %0d pulses occ %0d expected 0 occ 1", early, obs_occ); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (obs_exp !== 8'h01) begin n_fail++; $display("FAIL expire_pulse: got %h expected 01", obs_exp); end
        n_tests++; if (obs_occ !== 4'd0) begin n_fail++; $display("FAIL expire_occ: got %0d expected 0", obs_occ); end
        cycle(1'b1, mk(FT_HEAD, 7, 0), 1'b1);
        for (int i = 0; i < EXP; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk(FT_BODY, 7, 1), 1'b1);
        n_tests++; if (obs_exp !== '0 || obs_occ !== 4'd1) begin n_fail++; $display("FAIL expire_rescue: got exp %h occ %0d expected 00 occ 1", obs_exp, obs_occ); end
        early = 0;
        for (int i = 0; i < EXP; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (obs_exp !== '0) early++;
        end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (early != 0 || obs_exp !== 8'h01) begin n_fail++; $display("FAIL expire_restart: got %0d early, final %h expected 0 early, 01", early, obs_exp); end
    endtask

    task automatic test_overflow();
        int drops = 0;
        do_reset();
        cycle(1'b1, mk(FT_HEAD, 4, 0), 1'b1);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, mk(FT_BODY, 4, i), 1'b1);
            if (obs_drop) drops++;
        end
        n_tests++; if (drops != 0) begin n_fail++; $display("FAIL ovf_early: got %0d drops expected 0", drops); end
        cycle(1'b1, mk(FT_BODY, 4, 4), 1'b1);
        n_tests++; if (obs_drop !== 1'b1 || obs_reason !== 2'd2) begin n_fail++; $display("FAIL ovf_drop: got %b/%0d expected 1/2", obs_drop, obs_reason); end
        n_tests++; if (obs_occ !== 4'd0) begin n_fail++; $display("FAIL ovf_occ: got %0d expected 0", obs_occ); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        cycle(1'b1, mk(FT_HEAD, 6, 0), 1'b0);
        cycle(1'b1, mk(FT_BODY, 6, 1), 1'b0);
        cycle(1'b1, mk(FT_TAIL, 6, 2), 1'b0);
        cycle(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_flit_valid !== 1'b0 || out_flit_last !== 1'b0) begin n_fail++; $display("FAIL middrain_valid: got %b/%b expected 0/0", out_flit_valid, out_flit_last); end
        n_tests++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL middrain_occ: got %0d expected 0", occupancy); end
        do_reset();
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (obs_ov !== 1'b0 || obs_occ !== 4'd0) begin n_fail++; $display("FAIL middrain_after: got v=%b occ=%0d expected 0/0", obs_ov, obs_occ); end
    endtask

    task automatic test_random();
        flit_t f;
        bit    v = 0;
        int    hold = 0;
        int    p, r;
        do_reset();
        f = '0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0 || hold > 4) begin
                hold = 0;
                v = ($urandom_range(0, 9) < 7);
                p = $urandom_range(0, 7);
                r = $urandom_range(0, 9);
                f.ftype     = (r == 0) ? FT_IDLE : (r < 3) ? FT_HEAD : (r < 7) ? FT_BODY : FT_TAIL;
                f.packet_id = 8'(p);
                f.flit_num  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 4)) : 8'(m_exp[p]);
                f.payload   = $urandom;
            end
            cycle(v, f, ($urandom_range(0, 3) != 0));
            hold = (v && !exp_rdy) ? hold + 1 : 0;
            n_tests++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, obs_rdy, exp_rdy); end
            n_tests++; if (obs_ov !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", c, obs_ov, exp_ov); end
            if (exp_ov) begin
                n_tests++; if (obs_of !== exp_of || obs_ol !== exp_ol) begin n_fail++; $display("FAIL rnd_out_flit c%0d: got %h/%b expected %h/%b", c, obs_of, obs_ol, exp_of, exp_ol); end
            end
            n_tests++; if (obs_drop !== m_drop) begin n_fail++; $display("FAIL rnd_drop c%0d: got %b expected %b", c, obs_drop, m_drop); end
            if (m_drop) begin
                n_tests++; if (int'(obs_reason) != m_reason) begin n_fail++; $display("FAIL rnd_reason c%0d: got %0d expected %0d", c, obs_reason, m_reason); end
            end
            n_tests++; if ($countones(obs_exp) != m_expcnt) begin n_fail++; $display("FAIL rnd_expired c%0d: got %h expected %0d bits", c, obs_exp, m_expcnt); end
            n_tests++; if (int'(obs_occ) != m_busy) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, obs_occ, m_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_full();
        test_seq_orphan();
        test_expire();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
